// File: rtl/pipe_dp_pkg.sv
// pipe_dp_pkg: ALU codes, forward selects and instruction field positions for the datapath
package pipe_dp_pkg;
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;
  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_RESW = 2'b01,
    FWD_ALUM = 2'b10,
    FWD_ZERO = 2'b11
  } fwd_sel_e;
  localparam int OP_HI = 31, OP_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int IMM_HI = 15, IMM_LO = 0;
  localparam int FN_HI = 5, FN_LO = 0;
endpackage

// File: rtl/pipe_alu.sv
// pipe_alu: XLEN-wide combinational ALU; unknown op codes yield zero
module pipe_alu
  import pipe_dp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_ctl,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_y
);
  // select the result for the requested operation
  always_comb
    o_y = i_ctl == ALU_ADD ? i_a + i_b :
          i_ctl == ALU_SUB ? i_a - i_b :
          i_ctl == ALU_AND ? i_a & i_b :
          i_ctl == ALU_OR  ? i_a | i_b :
          i_ctl == ALU_SLT ? {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)} : '0;
endmodule

// File: rtl/pipe_datapath_gen.sv
// pipe_datapath_gen: parametrised 5-stage MIPS-subset datapath; define PIPE_FWD_EN to enable forwarding muxes
module pipe_datapath_gen
  import pipe_dp_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcsrcD,
  input  logic            regdstE,
  input  logic            alusrcE,
  input  logic            memwriteM,
  input  logic            memreadM,
  input  logic            memtoregW,
  input  logic            regwriteW,
  input  logic [2:0]      alucontrolE,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            flushE,
  input  logic            forwardAD,
  input  logic            forwardBD,
  input  logic [1:0]      forwardAE,
  input  logic [1:0]      forwardBE,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_we,
  output logic            dmem_re,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic            memstall,
  output logic            equalD,
  output logic [5:0]      op,
  output logic [5:0]      funct,
  output logic [4:0]      rsD,
  output logic [4:0]      rtD,
  output logic [4:0]      rsE,
  output logic [4:0]      rtE,
  output logic [4:0]      writeregE,
  output logic [4:0]      writeregM,
  output logic [4:0]      writeregW,
  output logic            validW
);
  typedef struct packed {logic [31:0] instr; logic [XLEN-1:0] pcplus1; logic valid;} fd_t;
  typedef struct packed {logic [XLEN-1:0] rd1, rd2, signimm; logic [4:0] rs, rt, rd; logic valid;} de_t;
  typedef struct packed {logic [XLEN-1:0] aluout, writedata; logic [4:0] writereg; logic valid;} em_t;
  typedef struct packed {logic [XLEN-1:0] readdata, aluout; logic [4:0] writereg; logic valid;} mw_t;
  logic [XLEN-1:0] r_pc;
  fd_t r_fd;
  de_t r_de;
  em_t r_em;
  mw_t r_mw;
  logic [XLEN-1:0] r_rf [32];
  logic [XLEN-1:0] w_pcplus1F, w_pcnext, w_signimmD, w_pcbranchD, w_rd1, w_rd2;
  logic [XLEN-1:0] w_srcAD, w_srcBD, w_srcAE, w_writedataE, w_srcBE, w_aluoutE, w_resultW;
  logic w_we;
  assign w_pcplus1F  = r_pc + XLEN'(1);
  assign w_signimmD  = {{(XLEN-16){r_fd.instr[IMM_HI]}}, r_fd.instr[IMM_HI:IMM_LO]};
  assign w_pcbranchD = r_fd.pcplus1 + w_signimmD;
  assign w_pcnext    = pcsrcD ? w_pcbranchD : w_pcplus1F;
  assign op          = r_fd.instr[OP_HI:OP_LO];
  assign funct       = r_fd.instr[FN_HI:FN_LO];
  assign rsD         = r_fd.instr[RS_HI:RS_LO];
  assign rtD         = r_fd.instr[RT_HI:RT_LO];
  assign w_resultW   = memtoregW ? r_mw.readdata : r_mw.aluout;
  assign w_we        = regwriteW & r_mw.valid;
  assign w_rd1 = rsD == '0 ? '0 : (w_we && writeregW == rsD) ? w_resultW : r_rf[rsD];
  assign w_rd2 = rtD == '0 ? '0 : (w_we && writeregW == rtD) ? w_resultW : r_rf[rtD];
`ifdef PIPE_FWD_EN
  assign w_srcAD = forwardAD ? r_em.aluout : w_rd1;
  assign w_srcBD = forwardBD ? r_em.aluout : w_rd2;
  assign w_srcAE = forwardAE == FWD_RESW ? w_resultW :
                   forwardAE == FWD_ALUM ? r_em.aluout :
                   forwardAE == FWD_ZERO ? '0 : r_de.rd1;
  assign w_writedataE = forwardBE == FWD_RESW ? w_resultW :
                        forwardBE == FWD_ALUM ? r_em.aluout :
                        forwardBE == FWD_ZERO ? '0 : r_de.rd2;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{forwardAD, forwardBD, forwardAE, forwardBE};
  assign w_srcAD      = w_rd1;
  assign w_srcBD      = w_rd2;
  assign w_srcAE      = r_de.rd1;
  assign w_writedataE = r_de.rd2;
`endif
  assign equalD    = w_srcAD == w_srcBD;
  assign rsE       = r_de.rs;
  assign rtE       = r_de.rt;
  assign writeregE = regdstE ? r_de.rd : r_de.rt;
  assign w_srcBE   = alusrcE ? r_de.signimm : w_writedataE;
  pipe_alu #(.XLEN(XLEN)) u_alu (.i_ctl(alucontrolE), .i_a(w_srcAE), .i_b(w_srcBE), .o_y(w_aluoutE));
  assign dmem_addr  = r_em.aluout;
  assign dmem_wdata = r_em.writedata;
  assign dmem_we    = memwriteM & r_em.valid;
  assign dmem_re    = memreadM & r_em.valid;
  assign memstall   = r_em.valid & (memwriteM | memreadM) & ~dmem_ready;
  assign writeregM  = r_em.writereg;
  assign writeregW  = r_mw.writereg;
  assign validW     = r_mw.valid;
  assign imem_addr  = r_pc;
  // PC advances unless the hazard unit or a pending memory access holds fetch
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_pc <= RESET_PC;
    else if (!(stallF || memstall)) r_pc <= w_pcnext;
  // F/D: hold on stall, squash the wrong-path fetch on a taken branch
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_fd <= '0;
    else if (!memstall && !stallD) r_fd <= pcsrcD ? '0 : {imem_rdata, w_pcplus1F, 1'b1};
  // D/E: hold on memory stall, insert a bubble on flush
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_de <= '0;
    else if (!memstall)
      r_de <= flushE ? '0 : {w_rd1, w_rd2, w_signimmD, rsD, rtD, r_fd.instr[RD_HI:RD_LO], r_fd.valid};
  // E/M: frozen while the memory access is outstanding
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_em <= '0;
    else if (!memstall) r_em <= {w_aluoutE, w_writedataE, writeregE, r_de.valid};
  // M/W: a stalled access sends a bubble to writeback
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_mw <= '0;
    else r_mw <= memstall ? '0 : {dmem_rdata, r_em.aluout, r_em.writereg, r_em.valid};
  // register file write; r0 stays zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    else if (w_we && writeregW != '0) r_rf[writeregW] <= w_resultW;
endmodule
